// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encodings, default code width and counter sizing helper
package decoder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam int IN_W_DEF = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/decoder_3to8_seq_dwell_counter.sv
// dwell_counter: counts enabled cycles and flags the last cycle of each DWELL-long period
module dwell_counter import decoder_pkg::*; #(
    parameter int DWELL = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic wrap
);
    localparam int W = (DWELL > 1) ? clog2(DWELL) : 1;

    logic [W-1:0] cnt;

    assign wrap = inc && cnt == W'(DWELL - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr || wrap)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/decoder_3to8_seq.sv
// decoder_3to8_seq: registered binary-to-one-hot decoder with valid/ready intake
// and a self-running one-hot scan used as an encoder stimulus source
module decoder_3to8_seq import decoder_pkg::*; #(
    parameter  int IN_W  = IN_W_DEF,
    parameter  int DWELL = 100,
    localparam int OUT_W = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             start,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic             scan_done
);
    state_t          state;
    logic [IN_W-1:0] code;
    logic [IN_W-1:0] nxt_code;
    logic            accept;
    logic            scan_go;
    logic            wrap;

    assign in_ready = en && state != ST_SCAN && !start;
    assign accept   = in_valid && in_ready;
    assign scan_go  = en && start && state != ST_SCAN;
    assign nxt_code = code + 1'b1;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (scan_go),
        .inc  (en && state == ST_SCAN),
        .wrap (wrap)
    );

    // en low blanks the outputs but keeps state and code so the display resumes later
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= ST_IDLE;
            code       <= '0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (!en) begin
                out_onehot <= '0;
                out_valid  <= 1'b0;
            end else if (scan_go) begin
                state      <= ST_SCAN;
                code       <= '0;
                out_onehot <= OUT_W'(1);
                out_valid  <= 1'b1;
            end else if (accept) begin
                state      <= ST_HOLD;
                code       <= in_code;
                out_onehot <= OUT_W'(1) << in_code;
                out_valid  <= 1'b1;
            end else if (state == ST_SCAN && wrap && &code) begin
                state      <= ST_IDLE;
                code       <= '0;
                out_onehot <= '0;
                out_valid  <= 1'b0;
                scan_done  <= 1'b1;
            end else if (state == ST_SCAN && wrap) begin
                code       <= nxt_code;
                out_onehot <= OUT_W'(1) << nxt_code;
                out_valid  <= 1'b1;
            end else if (state != ST_IDLE) begin
                out_onehot <= OUT_W'(1) << code;
                out_valid  <= 1'b1;
            end
        end
endmodule

// File: tb/tb_decoder_3to8_seq.sv
// tb_decoder_3to8_seq: scoreboard bench for decode, scan, collision, en gating and reset
module tb_decoder_3to8_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1, in_valid = 1'b0, start = 1'b0;
    logic [2:0] in_code = '0;
    logic       rdy, ov, sd;
    logic [7:0] oh;
    logic       en1 = 1'b1, in_valid1 = 1'b0, start1 = 1'b0;
    logic [2:0] in_code1 = '0;
    logic       rdy1, ov1, sd1;
    logic [7:0] oh1;

    typedef struct {
        string      ph;
        logic       sel;
        logic [7:0] oh;
        logic       v;
        logic       d;
    } exp_t;

    exp_t  q[$];
    int    n_chk = 0, n_pass = 0;
    string ph = "rst";
    logic  sel_g = 1'b0;

    always #5 clk = ~clk;

    decoder_3to8_seq #(.IN_W(3), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy),
        .in_code(in_code), .start(start), .out_onehot(oh), .out_valid(ov), .scan_done(sd)
    );

    decoder_3to8_seq #(.IN_W(3), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .in_valid(in_valid1), .in_ready(rdy1),
        .in_code(in_code1), .start(start1), .out_onehot(oh1), .out_valid(ov1), .scan_done(sd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // expected result for the coming edge; the monitor compares it at the following negedge
    task automatic step(input logic [7:0] e_oh, input logic e_v, input logic e_d,
                        input logic ck_rdy, input logic e_rdy);
        #1;
        if (ck_rdy) check({ph, ".rdy"}, {31'd0, sel_g ? rdy1 : rdy}, {31'd0, e_rdy});
        q.push_back('{ph, sel_g, e_oh, e_v, e_d});
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.ph, ".oh"}, {24'd0, e.sel ? oh1 : oh}, {24'd0, e.oh});
            check({e.ph, ".valid"}, {31'd0, e.sel ? ov1 : ov}, {31'd0, e.v});
            check({e.ph, ".done"}, {31'd0, e.sel ? sd1 : sd}, {31'd0, e.d});
        end

    // scan on the DWELL=4 instance; en low for m edges from edge offset lo; stop>0 aborts early
    task automatic run_scan(input int lo, input int m, input int stop);
        int         eff;
        logic       low;
        logic [7:0] pat;
        start = 1'b1;
        step(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        for (int e = 1; e <= 32 + m; e++) begin
            if (stop > 0 && e > stop) return;
            low = m > 0 && e >= lo && e < lo + m;
            en  = !low;
            eff = (m > 0 && e >= lo + m) ? e - m : e;
            pat = 8'h01 << (eff / 4);
            if (low) step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (eff == 32) step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            else step(pat, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        en = 1'b1;
        in_valid = 1'b0;
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        #3;
        check("rst.oh", {24'd0, oh}, 32'd0);
        check("rst.valid", {31'd0, ov}, 32'd0);
        check("rst.done", {31'd0, sd}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst.rdy", {31'd0, rdy}, 32'd1);

        ph = "decode";
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_code  = 3'(i);
            pat = 8'h01 << i;
            step(pat, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        in_valid = 1'b0;
        ph = "hold";
        step(8'h80, 1'b1, 1'b0, 1'b1, 1'b1);

        ph = "collide";
        in_valid = 1'b1;
        in_code  = 3'd5;
        run_scan(0, 0, 0);

        ph = "scan4";
        run_scan(0, 0, 0);

        ph = "en_gate";
        run_scan(13, 3, 0);

        ph = "rst_mid";
        run_scan(0, 0, 21);
        rst_n = 1'b0;
        #1;
        check("rst_mid.oh", {24'd0, oh}, 32'd0);
        check("rst_mid.valid", {31'd0, ov}, 32'd0);
        check("rst_mid.done", {31'd0, sd}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_mid.hold_done", {31'd0, sd}, 32'd0);
        rst_n = 1'b1;
        ph = "post_rst";
        in_valid = 1'b1;
        in_code  = 3'd2;
        step(8'h04, 1'b1, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;

        ph = "scan1";
        sel_g  = 1'b1;
        start1 = 1'b1;
        step(8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
        start1 = 1'b0;
        for (int e = 1; e < 8; e++) begin
            pat = 8'h01 << e;
            step(pat, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        check("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
